// File: rtl/counter_readout.sv
// counter_readout: snapshots two live counter values on request and streams
// them out as a byte frame (HEADER, Count0 LSB-first, Count1 LSB-first) over a
// valid/ready handshake while the counters keep running.
// Optional trailing XOR checksum byte: define COUNTER_READOUT_CHECKSUM_EN.
module counter_readout #(
  parameter int          CNT_W  = 64,
  parameter logic [7:0]  HEADER = 8'hA5
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [CNT_W-1:0] Count0,
  input  logic [CNT_W-1:0] Count1,
  input  logic             Req,
  input  logic             Ready,
  output logic [7:0]       Data,
  output logic             Valid,
  output logic             Busy,
  output logic             Done
);

  localparam int NB    = CNT_W / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_BODY0,
    S_BODY1,
    S_CSUM
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   snap0_q, snap0_d;
  logic [CNT_W-1:0]   snap1_q, snap1_d;
  logic [7:0]         data_q, data_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifdef COUNTER_READOUT_CHECKSUM_EN
  logic [7:0]         csum_q, csum_d;
`endif

  // Byte-lane views of the snapshots so the body states select a lane by index.
  logic [7:0] snap0_bytes [NB];
  logic [7:0] snap1_bytes [NB];

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_lanes
      assign snap0_bytes[gi] = snap0_q[8*gi +: 8];
      assign snap1_bytes[gi] = snap1_q[8*gi +: 8];
    end
  endgenerate

  logic [IDX_W-1:0] idx_inc;
  logic             idx_last;

  assign idx_inc  = idx_q + 1'b1;
  assign idx_last = (idx_q == IDX_W'(NB - 1));

  // Next-state and next-output logic; outputs are computed one cycle ahead so
  // that Data/Valid/Busy/Done come straight from flops.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap0_d = snap0_q;
    snap1_d = snap1_q;
    data_d  = data_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef COUNTER_READOUT_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        data_d  = 8'h00;
        if (Req) begin
          snap0_d = Count0;
          snap1_d = Count1;
          state_d = S_HDR;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          data_d  = HEADER;
`ifdef COUNTER_READOUT_CHECKSUM_EN
          csum_d  = 8'h00;
`endif
        end
      end
      S_HDR: begin
        if (Ready) begin
          state_d = S_BODY0;
          idx_d   = '0;
          data_d  = snap0_bytes[0];
        end
      end
      S_BODY0: begin
        if (Ready) begin
`ifdef COUNTER_READOUT_CHECKSUM_EN
          csum_d = csum_q ^ data_q;
`endif
          if (idx_last) begin
            state_d = S_BODY1;
            idx_d   = '0;
            data_d  = snap1_bytes[0];
          end else begin
            idx_d   = idx_inc;
            data_d  = snap0_bytes[idx_inc];
          end
        end
      end
      S_BODY1: begin
        if (Ready) begin
`ifdef COUNTER_READOUT_CHECKSUM_EN
          csum_d = csum_q ^ data_q;
`endif
          if (idx_last) begin
            idx_d = '0;
`ifdef COUNTER_READOUT_CHECKSUM_EN
            state_d = S_CSUM;
            data_d  = csum_q ^ data_q;
`else
            state_d = S_IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            data_d  = 8'h00;
`endif
          end else begin
            idx_d  = idx_inc;
            data_d = snap1_bytes[idx_inc];
          end
        end
      end
`ifdef COUNTER_READOUT_CHECKSUM_EN
      S_CSUM: begin
        if (Ready) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          data_d  = 8'h00;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        data_d  = 8'h00;
      end
    endcase
  end

  // State, snapshot and output registers; Reset aborts any frame on the spot.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      snap0_q <= '0;
      snap1_q <= '0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef COUNTER_READOUT_CHECKSUM_EN
      csum_q  <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      snap0_q <= snap0_d;
      snap1_q <= snap1_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef COUNTER_READOUT_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign Data  = data_q;
  assign Valid = valid_q;
  assign Busy  = busy_q;
  assign Done  = done_q;

endmodule

// File: doc/counter_readout.md
Name: counter_readout

Overview:
- Downstream consumer of the dual 64-bit event counter (outputs Output0/Output1).
- On a request, snapshots both counts atomically and streams them out as a byte frame over a valid/ready handshake.
- Feeds a UART or debug byte sink.
- Decouples counter operation (counter keeps running) from a slow readout path.

Parameters:
- CNT_W, 64, counter width in bits; must be a multiple of 8 and ≥ 8.
- HEADER, 8'hA5, frame start byte.

Ports:
- Clk  input  1  system clock, all logic on rising edge
- Reset  input  1  synchronous, active-high reset
- Count0  input  CNT_W  live count from counter channel 0
- Count1  input  CNT_W  live count from counter channel 1
- Req  input  1  snapshot/readout request, sampled each cycle
- Ready  input  1  downstream sink accepts Data this cycle
- Data  output  8  frame byte
- Valid  output  1  Data valid
- Busy  output  1  frame in progress (snapshot held)
- Done  output  1  one-cycle pulse after last byte accepted

Behaviour:
- Reset is synchronous and active-high (Reset=1 at a rising Clk edge), single clock Clk.
- Reset values: Data=0, Valid=0, Busy=0, Done=0; FSM=IDLE; snapshot registers and byte index = 0.
- Handshake: a byte transfers on an edge where Valid=1 and Ready=1.
  - While Valid=1 and Ready=0, Data and Valid hold stable.
  - Valid never drops without a transfer, except on Reset.
- Frame order: HEADER, then Count0 bytes LSB first, then Count1 bytes LSB first. Total 1+2*CNT_W/8 bytes (17 at default).
- FSM states:
  - IDLE: Busy=0, Valid=0. On an edge with Req=1, latch Count0/Count1 into snapshot regs, go to HDR.
  - HDR: Valid=1, Data=HEADER, Busy=1. On transfer, go to BODY0 with idx=0.
  - BODY0: Data=snap0[8*idx +: 8]. On transfer, idx++. At idx=CNT_W/8-1, go to BODY1 with idx=0.
  - BODY1: same over snap1. On the last transfer, go to IDLE (or CSUM, see Optional Feature).
- Latency: Req sampled at edge N → Valid=1 with HEADER visible after edge N. One byte per cycle when Ready is held 1, with no bubbles between bytes.
- Done: 1 for exactly the cycle following the final transfer. Busy=0 in that same cycle.
- Req while Busy=1 is ignored and not queued. This includes Req in the cycle of the final transfer.
- Req in the Done cycle (FSM in IDLE) starts a new frame.
- Snapshot is immune to Count0/Count1 changes after the latch edge.
- Count0/Count1 wrap-around is the counter's concern; values are transmitted as-is (all-ones allowed).
- Reset mid-frame: abort immediately. Outputs return to reset values on that edge; no Done pulse.

Optional Feature:
- Macro: COUNTER_READOUT_CHECKSUM_EN.
- Defined:
  - Adds state CSUM after BODY1.
  - Data = XOR of all 2*CNT_W/8 body bytes; HEADER is excluded.
  - Same handshake rules as other bytes. Done follows the CSUM transfer.
  - Frame length is 18 bytes at default.
  - Running XOR resets at HDR entry.
- Undefined: no CSUM state, frame ends after BODY1, no checksum logic synthesized.

Test Plan:
- Reset=1 for 1 cycle, then idle 5 cycles → Valid=0, Busy=0, Done=0, Data=0 throughout.
- Count0=64'h5, Count1=64'h3, Req pulse, Ready=1 → bytes A5,05,00×7,03,00×7 on 17 consecutive cycles, Done pulse the next cycle.
  - With CHECKSUM_EN: 18th byte 06.
- Count0=64'h0123456789ABCDEF, Ready toggling 1/0 each cycle → bytes A5,EF,CD,AB,89,67,45,23,01 …
  - Data/Valid stable during Ready=0 cycles; no byte duplicated or lost.
- Req pulse, then Count0 changes every cycle during the frame → transmitted bytes equal the values latched at the Req edge.
- Req asserted every cycle for 40 cycles with Ready=1 → back-to-back frames, new HEADER in the cycle after each Done. Requests during Busy are ignored.
- Reset asserted after the 4th body byte → next cycle Valid=0, Busy=0, no Done.
  - Subsequent Req produces a full, correct frame.
